sram_dp_ctrl: RTL and testbench
===============================

Name: sram_dp_ctrl

Overview:
- Initiator-side controller for the generated 2-port SRAM macros, shown here on the sram8t128x96 port map: read port 1 (A1/CSB1/OEB1/O1) and masked-write port 2 (A2/CSB2/WEB2/WBM2/I2).
- Converts valid/ready read and write request channels from core logic into registered, timing-clean macro pin drives.
- Captures read data into a response FIFO so that backpressure never loses a macro read.
- Macro clocks CE1/CE2 are tied to clk at the parent level.

Parameters:
- ADDR_W, 7, macro address width (depth 2^ADDR_W).
- DATA_W, 96, macro word width; must be a multiple of 8.
- MASK_W, 12, byte-mask width; must equal DATA_W/8.
- RESP_DEPTH, 4, read-response FIFO entries; minimum 3.

Ports:
- clk  in  1  clock; same clock drives macro CE1/CE2.
- reset  in  1  asynchronous, active-high reset.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  read request accepted when valid&ready at posedge.
- rd_req_addr  in  ADDR_W  read address.
- rd_resp_valid  out  1  read data available.
- rd_resp_ready  in  1  consumer accepts rd_resp_data.
- rd_resp_data  out  DATA_W  read data, FIFO head.
- wr_req_valid  in  1  write request valid.
- wr_req_ready  out  1  write accepted when valid&ready.
- wr_req_addr  in  ADDR_W  write address.
- wr_req_data  in  DATA_W  write data.
- wr_req_mask  in  MASK_W  bit i enables byte [8i+7:8i].
- A1  out  ADDR_W  macro read address, registered.
- CSB1  out  1  macro read select, active-low, registered.
- OEB1  out  1  macro output enable, active-low; constant 0 out of reset.
- O1  in  DATA_W  macro read data, valid after the CE1 edge that samples CSB1=0.
- A2  out  ADDR_W  macro write address, registered.
- CSB2  out  1  macro write select, active-low, registered.
- WEB2  out  1  macro write enable, active-low, registered.
- WBM2  out  MASK_W  macro byte mask, registered.
- I2  out  DATA_W  macro write data, registered.

Behaviour:
- Reset values (asynchronous): CSB1=1, CSB2=1, WEB2=1, OEB1=0, A1=0, A2=0, WBM2=0, I2=0.
- Also cleared on reset: response FIFO empty, rd_resp_valid=0, in-flight counter 0.
- Reset mid-operation drops all in-flight reads and any write registered but not yet sampled by the macro. Forcing CSB2 high is what guarantees no partial write.
- Read pipeline, request accepted at edge N:
  - After edge N: A1 = addr, CSB1 = 0.
  - Edge N+1: macro samples; O1 updates.
  - Edge N+2: O1 is pushed into the FIFO; rd_resp_valid is high from then on.
  - Latency is 2 cycles; throughput is 1 read/cycle.
  - CSB1 returns to 1 in any cycle with no accepted read.
- Credit rule: rd_req_ready = (fifo_count + inflight) < RESP_DEPTH, where inflight (0..2) counts reads accepted but not yet pushed.
  - This is purely registered state, with no combinational path from rd_resp_ready.
  - The FIFO therefore never overflows. Push and pop in the same cycle is allowed.
- Response channel: rd_resp_data is held stable while rd_resp_valid=1 and rd_resp_ready=0. Responses are returned in request order.
- Write path: wr_req_ready = 1 whenever reset is low.
  - Accepted at edge N: after N, A2/I2/WBM2 are loaded, CSB2 = 0, WEB2 = 0; the macro writes at edge N+1.
  - Idle cycle: CSB2 = 1, WEB2 = 1; A2/I2/WBM2 hold.
  - wr_req_mask = 0 is still issued (no-op write).
- Ordering:
  - Read accepted at N+1 or later, same address as a write accepted at N: returns the new data, with no stall required.
  - Read and write accepted at the same edge, same address: returns old data (read-before-write), unless the optional feature below is enabled.
- Address wrap: addresses are used as-is; no range check.

Optional Feature:
- Macro SRAM_RD_WR_FWD_EN.
- When defined:
  - When read and write are accepted in the same cycle with rd_req_addr == wr_req_addr, the write data and mask travel with the read down the pipeline.
  - At FIFO push, each byte whose mask bit is 1 takes the forwarded write byte; all others take O1.
  - The response therefore equals post-write memory contents.
- When undefined: no forwarding logic; read-before-write as stated above.

Test Plan:
- Reset, then write addr 5, data 96'h0123...AB (all bytes distinct), mask 12'hFFF; read addr 5 two cycles later with rd_resp_ready=1 -> rd_resp_valid asserted 2 cycles after the read is accepted, data equals the written word.
- Write addr 9 with data all 0xFF, mask 12'hFFF; then write addr 9 with data 0, mask 12'h00F; read addr 9 -> low 32 bits 0, upper 64 bits all 1s.
- Hold rd_resp_ready=0 while issuing reads back-to-back -> exactly 4 accepted, then rd_req_ready=0. Release -> 4 responses in order, with data stable while stalled.
- Same-cycle read and write to addr 3 (old data 96'h0, write 96'h1 mask 12'h001) -> response 0 without the macro, 1 with SRAM_RD_WR_FWD_EN defined.
- Assert reset with 2 reads in flight and a pending write to addr 7 -> CSB1/CSB2/WEB2 go to 1 immediately, no responses emerge, and addr 7 keeps its old value.
- Streaming 100 reads with rd_resp_ready=1 -> one response per cycle after the 2-cycle fill, with no bubbles.

Source files
------------

// File: rtl/sram_dp_ctrl.sv
// sram_dp_ctrl: initiator-side controller for a 2-port SRAM macro (read port 1, masked-write port 2).
// Turns valid/ready read and write request channels into registered macro pin drives, and
// captures read data into a credit-protected response FIFO so backpressure never drops a read.
// Ports: clk/reset (async, active-high); rd_req_* read request channel; rd_resp_* read response
// channel (FIFO head); wr_req_* write request channel; A1/CSB1/OEB1/O1 macro read port;
// A2/CSB2/WEB2/WBM2/I2 macro write port. CE1/CE2 are tied to clk by the parent.
// Optional macro SRAM_RD_WR_FWD_EN: forward same-cycle same-address write bytes into the read response.
module sram_dp_ctrl #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 96,
  parameter int MASK_W     = 12,
  parameter int RESP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  input  logic [MASK_W-1:0] wr_req_mask,
  output logic [ADDR_W-1:0] A1,
  output logic              CSB1,
  output logic              OEB1,
  input  logic [DATA_W-1:0] O1,
  output logic [ADDR_W-1:0] A2,
  output logic              CSB2,
  output logic              WEB2,
  output logic [MASK_W-1:0] WBM2,
  output logic [DATA_W-1:0] I2
);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 3);
  logic [ADDR_W-1:0] r_a1, r_a2;
  logic              r_csb1, r_csb2, r_web2;
  logic [MASK_W-1:0] r_wbm2;
  logic [DATA_W-1:0] r_i2;
  logic              r_v2;
  logic [DATA_W-1:0] r_fifo [RESP_DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_cnt;
  logic              w_rd_acc, w_wr_acc, w_pop;
  logic [CW-1:0]     w_occ;
  logic [DATA_W-1:0] w_push_data;
  // Credits cover FIFO entries plus reads still in the macro pipeline (CSB1 stage and O1 stage),
  // so a push can never find the FIFO full; no path from rd_resp_ready.
  assign w_occ         = r_cnt + CW'(!r_csb1) + CW'(r_v2);
  assign rd_req_ready  = w_occ < CW'(RESP_DEPTH);
  assign w_rd_acc      = rd_req_valid & rd_req_ready;
  assign wr_req_ready  = !reset;
  assign w_wr_acc      = wr_req_valid & wr_req_ready;
  assign rd_resp_valid = r_cnt != '0;
  assign rd_resp_data  = r_fifo[r_rp];
  assign w_pop         = rd_resp_valid & rd_resp_ready;
  assign A1   = r_a1;
  assign CSB1 = r_csb1;
  assign OEB1 = 1'b0;
  assign A2   = r_a2;
  assign CSB2 = r_csb2;
  assign WEB2 = r_web2;
  assign WBM2 = r_wbm2;
  assign I2   = r_i2;
`ifdef SRAM_RD_WR_FWD_EN
  // Write bytes ride alongside a same-address read; mask is zero for any other read.
  logic [MASK_W-1:0] r_fm1, r_fm2;
  logic [DATA_W-1:0] r_fd1, r_fd2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fm1 <= '0;
      r_fm2 <= '0;
      r_fd1 <= '0;
      r_fd2 <= '0;
    end else begin
      r_fm1 <= (w_rd_acc && w_wr_acc && rd_req_addr == wr_req_addr) ? wr_req_mask : '0;
      r_fd1 <= wr_req_data;
      r_fm2 <= r_fm1;
      r_fd2 <= r_fd1;
    end
  end
  always_comb begin
    w_push_data = O1;
    for (int i = 0; i < MASK_W; i++)
      w_push_data[8*i +: 8] = r_fm2[i] ? r_fd2[8*i +: 8] : O1[8*i +: 8];
  end
`else
  assign w_push_data = O1;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a1   <= '0;
      r_csb1 <= 1'b1;
      r_a2   <= '0;
      r_csb2 <= 1'b1;
      r_web2 <= 1'b1;
      r_wbm2 <= '0;
      r_i2   <= '0;
      r_v2   <= 1'b0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
    end else begin
      r_csb1 <= !w_rd_acc;
      if (w_rd_acc) r_a1 <= rd_req_addr;
      r_v2   <= !r_csb1;
      r_csb2 <= !w_wr_acc;
      r_web2 <= !w_wr_acc;
      if (w_wr_acc) begin
        r_a2   <= wr_req_addr;
        r_i2   <= wr_req_data;
        r_wbm2 <= wr_req_mask;
      end
      if (r_v2) r_wp <= (r_wp == PW'(RESP_DEPTH - 1)) ? '0 : r_wp + 1'b1;
      if (w_pop) r_rp <= (r_rp == PW'(RESP_DEPTH - 1)) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(r_v2) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (r_v2) r_fifo[r_wp] <= w_push_data;
  end
endmodule

// File: tb/tb_sram_dp_ctrl.sv
// tb_sram_dp_ctrl: directed and randomized bench for sram_dp_ctrl with a behavioural macro and reference memory.
module tb_sram_dp_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req_valid, rd_req_ready, rd_resp_valid, rd_resp_ready;
  logic [6:0]  rd_req_addr, wr_req_addr, A1, A2;
  logic [95:0] rd_resp_data, wr_req_data, I2;
  logic [95:0] O1 = '0;
  logic        wr_req_valid, wr_req_ready, CSB1, OEB1, CSB2, WEB2;
  logic [11:0] wr_req_mask, WBM2;
  sram_dp_ctrl dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data), .wr_req_mask(wr_req_mask),
    .A1(A1), .CSB1(CSB1), .OEB1(OEB1), .O1(O1),
    .A2(A2), .CSB2(CSB2), .WEB2(WEB2), .WBM2(WBM2), .I2(I2)
  );
  always #5 clk = ~clk;
  logic [95:0] sram [128];
  logic [95:0] ref_mem [128];
  logic [95:0] q [$];
  logic [95:0] tmp, stall_data;
  logic        stall_prev = 1'b0;
  logic        mon_en = 1'b0;
  int total = 0, passed = 0, failed = 0;
  function automatic logic [95:0] merge(input logic [95:0] old, input logic [95:0] d, input logic [11:0] m);
    logic [95:0] r = old;
    for (int i = 0; i < 12; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction
  always @(posedge clk) begin
    if (!CSB1) O1 <= sram[A1];
    if (!CSB2 && !WEB2) begin
      tmp = merge(sram[A2], I2, WBM2);
      sram[A2] <= tmp;
    end
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Handshakes are stable here and take effect at the next posedge.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("rd_req_ready_credit", rd_req_ready, q.size() < 4);
      if (stall_prev) chk("stall_data", rd_resp_data, stall_data);
      stall_prev = rd_resp_valid && !rd_resp_ready;
      stall_data = rd_resp_data;
      if (rd_resp_valid && rd_resp_ready) begin
        if (q.size() == 0) chk("resp_extra", rd_resp_valid, 0);
        else chk("resp_data", rd_resp_data, q.pop_front());
      end
`ifdef SRAM_RD_WR_FWD_EN
      if (wr_req_valid && wr_req_ready) ref_mem[wr_req_addr] = merge(ref_mem[wr_req_addr], wr_req_data, wr_req_mask);
      if (rd_req_valid && rd_req_ready) q.push_back(ref_mem[rd_req_addr]);
`else
      if (rd_req_valid && rd_req_ready) q.push_back(ref_mem[rd_req_addr]);
      if (wr_req_valid && wr_req_ready) ref_mem[wr_req_addr] = merge(ref_mem[wr_req_addr], wr_req_data, wr_req_mask);
`endif
    end
  end
  localparam logic [95:0] W1 = 96'h0123456789ABCDEF10325476;
  localparam logic [95:0] WA = 96'hA5A5A5A5_5A5A5A5A_C3C3C3C3;
  localparam logic [95:0] WB = 96'h11111111_22222222_33333333;
  initial begin
    logic [6:0]  al [8];
    logic [95:0] e4;
    int n, acc, nv, first, last;
    al = '{7'd5, 7'd9, 7'd3, 7'd0, 7'd1, 7'd2, 7'd4, 7'd6};
    for (int i = 0; i < 128; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1;
    rd_req_valid = 0; rd_req_addr = '0; rd_resp_ready = 1;
    wr_req_valid = 0; wr_req_addr = '0; wr_req_data = '0; wr_req_mask = '0;
    tick; tick;
    chk("rst_CSB1", CSB1, 1); chk("rst_CSB2", CSB2, 1); chk("rst_WEB2", WEB2, 1);
    chk("rst_OEB1", OEB1, 0); chk("rst_A1", A1, 0); chk("rst_A2", A2, 0);
    chk("rst_WBM2", WBM2, 0); chk("rst_I2", I2, 0);
    chk("rst_resp_valid", rd_resp_valid, 0); chk("rst_wr_ready", wr_req_ready, 0);
    reset = 1'b0;
    tick;
    mon_en = 1'b1;
    chk("idle_rd_ready", rd_req_ready, 1); chk("idle_wr_ready", wr_req_ready, 1);
    // full write, then read back
    wr_req_valid = 1; wr_req_addr = 7'd5; wr_req_data = W1; wr_req_mask = 12'hFFF;
    tick;
    wr_req_valid = 0;
    chk("wr_A2", A2, 5); chk("wr_I2", I2, W1); chk("wr_WBM2", WBM2, 12'hFFF);
    chk("wr_CSB2", CSB2, 0); chk("wr_WEB2", WEB2, 0);
    tick;
    chk("wr_idle_CSB2", CSB2, 1); chk("wr_idle_WEB2", WEB2, 1); chk("wr_idle_A2", A2, 5);
    rd_req_valid = 1; rd_req_addr = 7'd5;
    tick;
    rd_req_valid = 0;
    chk("rd_CSB1", CSB1, 0); chk("rd_A1", A1, 5); chk("lat0_valid", rd_resp_valid, 0);
    tick;
    chk("rd_CSB1_idle", CSB1, 1); chk("lat1_valid", rd_resp_valid, 0);
    tick;
    chk("lat2_valid", rd_resp_valid, 1); chk("t1_data", rd_resp_data, W1);
    tick;
    // partial-mask overwrite, read accepted right after the write
    wr_req_valid = 1; wr_req_addr = 7'd9; wr_req_data = '1; wr_req_mask = 12'hFFF;
    tick;
    wr_req_data = '0; wr_req_mask = 12'h00F;
    tick;
    wr_req_valid = 0; rd_req_valid = 1; rd_req_addr = 7'd9;
    tick;
    rd_req_valid = 0;
    tick; tick;
    chk("t2_valid", rd_resp_valid, 1);
    chk("t2_data", rd_resp_data, {64'hFFFFFFFF_FFFFFFFF, 32'h0});
    tick; tick;
    // credit limit under backpressure
    rd_resp_ready = 0; rd_req_valid = 1; n = 0;
    for (int i = 0; i < 8; i++) begin
      rd_req_addr = al[i];
      if (rd_req_ready) n++;
      tick;
    end
    rd_req_valid = 0;
    chk("t3_accepted", n, 4); chk("t3_ready_low", rd_req_ready, 0);
    tick; tick;
    rd_resp_ready = 1; n = 0;
    for (int i = 0; i < 8; i++) begin
      if (rd_resp_valid) n++;
      tick;
    end
    chk("t3_responses", n, 4); chk("t3_ready_back", rd_req_ready, 1);
    // same-cycle read and write to one address
`ifdef SRAM_RD_WR_FWD_EN
    e4 = 96'h1;
`else
    e4 = '0;
`endif
    rd_req_valid = 1; rd_req_addr = 7'd3;
    wr_req_valid = 1; wr_req_addr = 7'd3; wr_req_data = 96'h1; wr_req_mask = 12'h001;
    tick;
    rd_req_valid = 0; wr_req_valid = 0;
    tick; tick;
    chk("t4_valid", rd_resp_valid, 1); chk("t4_data", rd_resp_data, e4);
    tick; tick;
    // reset with reads in flight and a write registered but not yet written
    wr_req_valid = 1; wr_req_addr = 7'd7; wr_req_data = WA; wr_req_mask = 12'hFFF;
    tick;
    wr_req_valid = 0;
    tick; tick;
    rd_req_valid = 1; rd_req_addr = 7'd5;
    tick;
    rd_req_addr = 7'd9; wr_req_valid = 1; wr_req_data = WB;
    tick;
    mon_en = 1'b0;
    reset = 1'b1;
    rd_req_valid = 0; wr_req_valid = 0;
    #1;
    chk("mid_rst_CSB1", CSB1, 1); chk("mid_rst_CSB2", CSB2, 1); chk("mid_rst_WEB2", WEB2, 1);
    tick; tick;
    reset = 1'b0;
    q.delete();
    stall_prev = 1'b0;
    ref_mem[7] = WA;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (rd_resp_valid) n++;
      tick;
    end
    chk("t5_no_resp", n, 0);
    mon_en = 1'b1;
    rd_req_valid = 1; rd_req_addr = 7'd7;
    tick;
    rd_req_valid = 0;
    tick; tick;
    chk("t5_addr7_old", rd_resp_data, WA);
    tick; tick;
    // streaming reads with random writes mixed in
    acc = 0; nv = 0; first = -1; last = -1;
    for (int c = 0; c < 104; c++) begin
      rd_req_valid = (c < 100);
      rd_req_addr = 7'($urandom_range(127));
      wr_req_valid = (c < 100) && ($urandom_range(1) == 1);
      wr_req_addr = 7'($urandom_range(127));
      wr_req_data = {$urandom, $urandom, $urandom};
      wr_req_mask = 12'($urandom);
      if (rd_req_valid && rd_req_ready) acc++;
      tick;
      if (rd_resp_valid) begin
        nv++;
        if (first < 0) first = c;
        last = c;
      end
    end
    chk("t6_accepted", acc, 100); chk("t6_responses", nv, 100);
    chk("t6_first", first, 2); chk("t6_last", last, 101);
    // fully random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      rd_req_valid = $urandom_range(1) == 1;
      rd_req_addr = 7'($urandom_range(127));
      rd_resp_ready = $urandom_range(3) != 0;
      wr_req_valid = $urandom_range(1) == 1;
      wr_req_addr = (c % 3 == 0) ? rd_req_addr : 7'($urandom_range(127));
      wr_req_data = {$urandom, $urandom, $urandom};
      wr_req_mask = 12'($urandom);
      tick;
    end
    rd_req_valid = 0; wr_req_valid = 0; rd_resp_ready = 1;
    for (int i = 0; i < 10; i++) tick;
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", rd_resp_valid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
